rx_frame_fifo: RTL and testbench

//  Consumes the byte stream from the RMII receive parser: UDP payload followed by the 4-byte FCS, with no backpressure.

---
 rtl/rmii_axis_pkg.sv | 17 +
 rtl/sdp_byte_ram.sv | 28 ++
 rtl/rx_frame_fifo.sv | 118 +++++++++++
 tb/tb_rx_frame_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_axis_pkg.sv
// Shared types and constants for the RMII receive to AXI-Stream frame path.
package rmii_axis_pkg;

  localparam int FCS_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_e;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_byte_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port with read enable.
module sdp_byte_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the stream data register, so it holds unless re is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive FIFO: strips the trailing FCS, commits whole frames,
// drops runts and overflowing frames, and replays committed frames on AXI-Stream.
module rx_frame_fifo
  import rmii_axis_pkg::*;
#(
  parameter int DEPTH     = 2048,
  parameter int FCS_BYTES = FCS_BYTES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_AXIS_TVALID,
  input  logic [7:0]       S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  output logic [7:0]       M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_drop
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int HW = $clog2(FCS_BYTES + 1);

  wr_state_e state, state_nxt;

  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, wr_adv;
  logic [FCS_BYTES-1:0][7:0] hb;
  logic [HW-1:0] hb_cnt;
  logic [DEPTH-1:0] last_q;
  logic m_valid, m_last;

  logic accept, hb_full, want_push, full, push, ovf, eof, commit, discard, load;

  // A byte is only written to the store once FCS_BYTES newer bytes sit behind it,
  // so the FCS never reaches the store.
  assign accept    = S_AXIS_TVALID && (state != W_DROP);
  assign hb_full   = (hb_cnt == HW'(FCS_BYTES));
  assign want_push = accept && hb_full;
  assign full      = ((wr_ptr - rd_ptr) == PW'(DEPTH));
  assign push      = want_push && !full;
  assign ovf       = want_push && full;
  assign wr_adv    = wr_ptr + PW'(push);

  assign eof     = S_AXIS_TLAST && ((state != W_IDLE) || S_AXIS_TVALID);
  assign commit  = eof && (state != W_DROP) && !ovf && (wr_adv != commit_ptr);
  assign discard = eof && !commit;

  assign load = (rd_ptr != commit_ptr) && (!m_valid || M_AXIS_TREADY);

  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_last;

  always_comb begin
    state_nxt = state;
    if (eof)                              state_nxt = W_IDLE;
    else if (ovf)                         state_nxt = W_DROP;
    else if (accept && state == W_IDLE)   state_nxt = W_FILL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= W_IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      hb          <= '0;
      hb_cnt      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frames_ok   <= '0;
      frames_drop <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= discard ? commit_ptr : wr_adv;
      if (commit) commit_ptr <= wr_adv;

      if (eof)                     hb_cnt <= '0;
      else if (accept && !hb_full) hb_cnt <= hb_cnt + HW'(1);
      if (accept) begin
        hb[0] <= S_AXIS_TDATA;
        for (int i = 1; i < FCS_BYTES; i++) hb[i] <= hb[i-1];
      end

      if (load) begin
        m_valid <= 1'b1;
        m_last  <= last_q[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PW'(1);
      end else if (M_AXIS_TREADY) begin
        m_valid <= 1'b0;
      end

      if (commit && frames_ok != {CNT_W{1'b1}})    frames_ok   <= frames_ok + CNT_W'(1);
      if (discard && frames_drop != {CNT_W{1'b1}}) frames_drop <= frames_drop + CNT_W'(1);
    end
  end

  // Commit marks the frame's final byte after the fact; the later assignment wins
  // when that byte is pushed in the same cycle.
  always_ff @(posedge clk) begin
    if (push)   last_q[wr_ptr[AW-1:0]] <= 1'b0;
    if (commit) last_q[AW'(wr_adv - PW'(1))] <= 1'b1;
  end

  sdp_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (hb[FCS_BYTES-1]),
    .re    (load),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (M_AXIS_TDATA)
  );

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: directed cases with literal expectations plus random frames
// checked beat by beat against a frame-level queue model.
module tb_rx_frame_fifo;

  localparam int DEPTH = 16;
  localparam int FCS   = 4;
  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_last;
  logic             m_ready = 1'b1;
  logic [CNT_W-1:0] frames_ok, frames_drop;

  rx_frame_fifo #(.DEPTH(DEPTH), .FCS_BYTES(FCS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TLAST  (s_last),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TREADY (m_ready),
    .frames_ok     (frames_ok),
    .frames_drop   (frames_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [8:0] sb[$];     // expected {data,last} beats still to come out
  logic [8:0] got[$];    // beats actually accepted downstream
  logic [7:0] frame[$];  // bytes of the frame currently being sent
  int m_ok = 0, m_drop = 0, occ0 = 0;
  int rdy_mode = 0, rph = 0;
  logic prev_hold = 1'b0;
  logic [8:0] prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 always, 1 random, 2 repeating 1,0,0,1, 3 stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      2:       begin m_ready = (rph % 4 == 0) || (rph % 4 == 3); rph++; end
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_out", 64'({m_valid, m_data, m_last}), 64'(0));
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold_stable", 64'({m_valid, m_data, m_last}), 64'({1'b1, prev_beat}));
      if (m_valid && m_ready) begin
        got.push_back({m_data, m_last});
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got %0h want none", {m_data, m_last});
        end else begin
          check("beat", 64'({m_data, m_last}), 64'(sb.pop_front()));
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_beat = {m_data, m_last};
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    s_valid = v; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
  endtask

  // Frame-level model: payload is everything but the last FCS bytes; empty payload is a
  // runt, and a payload larger than the free store space at frame start is an overflow.
  task automatic model_eof();
    if (frame.size() != 0) begin
      int pay;
      pay = frame.size() - FCS;
      if (pay <= 0 || pay > DEPTH - occ0) begin
        if (m_drop < MAXC) m_drop++;
      end else begin
        for (int i = 0; i < pay; i++) sb.push_back({frame[i], i == pay - 1});
        if (m_ok < MAXC) m_ok++;
      end
    end
    frame.delete();
    check("frames_ok", 64'(frames_ok), 64'(m_ok));
    check("frames_drop", 64'(frames_drop), 64'(m_drop));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d beats left want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // mode 0: TLAST with the final byte; mode 1: standalone TLAST after gap idle cycles.
  task automatic send_frame(input int len, input logic [7:0] first, input bit rnd,
                            input int mode, input int gap);
    // Only let a frame share the store with pending output when it surely fits,
    // so the overflow decision stays exact.
    if (len - FCS > 0 && len - FCS > DEPTH - sb.size()) wait_drain();
    occ0 = sb.size();
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = rnd ? 8'($urandom) : first + 8'(i);
      if (rnd && $urandom_range(0, 4) == 0) drive(1'b0, 8'h00, 1'b0);
      frame.push_back(d);
      drive(1'b1, d, (mode == 0) && (i == len - 1));
    end
    if (mode != 0 || len == 0) begin
      repeat (gap) drive(1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
    end
    model_eof();
  endtask

  task automatic check_got(input string name, input int n, input logic [7:0] first);
    check({name, "_len"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check({name, "_byte"}, 64'(got[i]), 64'({first + 8'(i), i == n - 1}));
    got.delete();
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ok", 64'(frames_ok), 64'(0));
    check("rst_drop", 64'(frames_drop), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: TLAST with the last byte, plus first-byte latency
    rdy_mode = 0;
    send_frame(10, 8'h01, 0, 0, 0);
    @(negedge clk);
    check("t1_lat_early", 64'(m_valid), 64'(0));
    @(negedge clk);
    check("t1_lat", 64'({m_valid, m_data}), 64'({1'b1, 8'h01}));
    wait_drain();
    check_got("t1", 6, 8'h01);
    check("t1_ok", 64'(frames_ok), 64'(1));

    // 2: standalone TLAST three cycles after the final byte
    send_frame(10, 8'h01, 0, 1, 2);
    wait_drain();
    check_got("t2", 6, 8'h01);
    check("t2_ok", 64'(frames_ok), 64'(2));

    // 3: runt, then a back-to-back 5-byte frame
    send_frame(3, 8'h31, 0, 0, 0);
    check("t3_drop", 64'(frames_drop), 64'(1));
    send_frame(5, 8'h35, 0, 0, 0);
    wait_drain();
    check_got("t3", 1, 8'h35);

    // 4: overflow drop, then a normal frame
    send_frame(30, 8'h40, 0, 0, 0);
    check("t4_drop", 64'(frames_drop), 64'(2));
    send_frame(8, 8'h50, 0, 0, 0);
    wait_drain();
    check_got("t4", 4, 8'h50);

    // 5: downstream stalls in a 1,0,0,1 pattern
    rph = 0; rdy_mode = 2;
    send_frame(8, 8'h11, 0, 0, 0);
    wait_drain();
    check_got("t5", 4, 8'h11);

    // 6: reset mid-frame with a committed frame still unread
    rdy_mode = 3;
    send_frame(8, 8'h60, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      frame.push_back(8'h70 + 8'(i));
      drive(1'b1, 8'h70 + 8'(i), 1'b0);
    end
    rst = 1'b0;
    sb.delete(); frame.delete(); m_ok = 0; m_drop = 0;
    @(negedge clk);
    check("t6_valid", 64'(m_valid), 64'(0));
    check("t6_ok", 64'(frames_ok), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    rdy_mode = 0;
    got.delete();
    send_frame(8, 8'h21, 0, 0, 0);
    wait_drain();
    check_got("t6", 4, 8'h21);
    check("t6_ok_after", 64'(frames_ok), 64'(1));

    // Random frames: lengths around the runt and overflow edges, random ready
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      int len, mode;
      len  = $urandom_range(0, 24);
      mode = (len == 0) ? 1 : int'($urandom_range(0, 1));
      send_frame(len, 8'h00, 1, mode, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) drive(1'b0, 8'h00, 1'b0);
    end
    wait_drain();
    check("final_ok", 64'(frames_ok), 64'(m_ok));
    check("final_drop", 64'(frames_drop), 64'(m_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
